// File: rtl/weight_load_sequencer.sv
// -----------------------------------------------------------------------------
// weight_load_sequencer
//
// Streams a flat image of trained coefficients into the neurons of the layer
// chain. Each accepted stream word becomes a one-cycle weight or bias write on
// the shared config bus. The target layer and neuron are driven alongside.
//
// Image order: for each layer 1..NUM_LAYERS, for each neuron 0..NN-1, the NW
// weight words come first and then one bias word.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle pulse; starts a load when idle
//   s_data/s_valid/    coefficient stream (AXI-Stream style); s_last marks
//   s_last/s_ready     the final word of the image
//   config_layer_num   target layer of the current write (1-based)
//   config_neuron_num  target neuron of the current write (0-based)
//   weightValue/Valid  weight word and its one-cycle write strobe
//   biasValue/Valid    bias word and its one-cycle write strobe
//   busy               high while a load is in progress
//   done               one-cycle pulse after a correctly framed image
//   err                sticky framing error; cleared by the next start or rst
// -----------------------------------------------------------------------------
module weight_load_sequencer #(
    parameter int                         NUM_LAYERS    = 2,
    parameter logic [16*NUM_LAYERS-1:0]   LAYER_NEURONS = {16'd10, 16'd30},
    parameter logic [16*NUM_LAYERS-1:0]   LAYER_WEIGHTS = {16'd30, 16'd784},
    parameter int                         DATA_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [31:0]           config_layer_num,
    output logic [31:0]           config_neuron_num,
    output logic [31:0]           weightValue,
    output logic                  weightValid,
    output logic [31:0]           biasValue,
    output logic                  biasValid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Layer index width; the lookup tables are padded to a power of two so
    // every value of the index register addresses a defined entry.
    localparam int LIDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int LUT_DEPTH = 1 << LIDX_W;
    localparam logic [LIDX_W-1:0] LAST_LAYER_IDX = LIDX_W'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_B,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Per-layer geometry tables unpacked from the packed parameters
    // ------------------------------------------------------------------
    logic [15:0] neurons_lut [LUT_DEPTH];
    logic [15:0] weights_lut [LUT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
            if (gi < NUM_LAYERS) begin : g_used
                assign neurons_lut[gi] = LAYER_NEURONS[16*gi +: 16];
                assign weights_lut[gi] = LAYER_WEIGHTS[16*gi +: 16];
            end else begin : g_unused
                assign neurons_lut[gi] = 16'd0;
                assign weights_lut[gi] = 16'd0;
            end
        end
    endgenerate

    // Stream word fitted to the 32-bit config bus
    logic [31:0] s_word;
    generate
        if (DATA_WIDTH >= 32) begin : g_trunc
            assign s_word = s_data[31:0];
        end else begin : g_ext
            assign s_word = {{(32-DATA_WIDTH){1'b0}}, s_data};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state_reg,        state_next;
    logic [LIDX_W-1:0]  layer_idx_reg,    layer_idx_next;
    logic [15:0]        neuron_reg,       neuron_next;
    logic [15:0]        widx_reg,         widx_next;
    logic [31:0]        layer_num_reg,    layer_num_next;
    logic [31:0]        neuron_num_reg,   neuron_num_next;
    logic [31:0]        weight_value_reg, weight_value_next;
    logic               weight_valid_reg, weight_valid_next;
    logic [31:0]        bias_value_reg,   bias_value_next;
    logic               bias_valid_reg,   bias_valid_next;
    logic               done_reg,         done_next;
    logic               err_reg,          err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            layer_idx_reg    <= '0;
            neuron_reg       <= '0;
            widx_reg         <= '0;
            layer_num_reg    <= '0;
            neuron_num_reg   <= '0;
            weight_value_reg <= '0;
            weight_valid_reg <= 1'b0;
            bias_value_reg   <= '0;
            bias_valid_reg   <= 1'b0;
            done_reg         <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            state_reg        <= state_next;
            layer_idx_reg    <= layer_idx_next;
            neuron_reg       <= neuron_next;
            widx_reg         <= widx_next;
            layer_num_reg    <= layer_num_next;
            neuron_num_reg   <= neuron_num_next;
            weight_value_reg <= weight_value_next;
            weight_valid_reg <= weight_valid_next;
            bias_value_reg   <= bias_value_next;
            bias_valid_reg   <= bias_valid_next;
            done_reg         <= done_next;
            err_reg          <= err_next;
        end
    end

    // ------------------------------------------------------------------
    // Walk decode
    // ------------------------------------------------------------------
    logic [LIDX_W-1:0] layer_idx_inc;
    logic [15:0]       cur_nn;
    logic [15:0]       cur_nw;
    logic [15:0]       nxt_nw;
    logic              last_weight;
    logic              last_neuron;
    logic              last_layer;
    logic              beat;

    assign layer_idx_inc = layer_idx_reg + 1'b1;
    assign cur_nn        = neurons_lut[layer_idx_reg];
    assign cur_nw        = weights_lut[layer_idx_reg];
    assign nxt_nw        = weights_lut[layer_idx_inc];
    // Compared in 17 bits so a 16-bit count of 65535 cannot wrap.
    assign last_weight   = ({1'b0, widx_reg}   + 17'd1) == {1'b0, cur_nw};
    assign last_neuron   = ({1'b0, neuron_reg} + 17'd1) == {1'b0, cur_nn};
    assign last_layer    = (layer_idx_reg == LAST_LAYER_IDX);

    assign s_ready = (state_reg == ST_LOAD_W) || (state_reg == ST_LOAD_B);
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_next        = state_reg;
        layer_idx_next    = layer_idx_reg;
        neuron_next       = neuron_reg;
        widx_next         = widx_reg;
        layer_num_next    = layer_num_reg;
        neuron_num_next   = neuron_num_reg;
        weight_value_next = weight_value_reg;
        weight_valid_next = 1'b0;
        bias_value_next   = bias_value_reg;
        bias_valid_next   = 1'b0;
        done_next         = 1'b0;
        err_next          = err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    layer_idx_next = '0;
                    neuron_next    = '0;
                    widx_next      = '0;
                    err_next       = 1'b0;
                    // A layer with no weights goes straight to its biases.
                    state_next     = (weights_lut[0] == 16'd0) ? ST_LOAD_B : ST_LOAD_W;
                end
            end

            ST_LOAD_W: begin
                if (beat) begin
                    weight_valid_next = 1'b1;
                    weight_value_next = s_word;
                    layer_num_next    = 32'(layer_idx_reg) + 32'd1;
                    neuron_num_next   = 32'(neuron_reg);
                    if (s_last) begin
                        // Image ended early: the word is written, load aborts.
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (last_weight) begin
                        state_next = ST_LOAD_B;
                    end else begin
                        widx_next = widx_reg + 16'd1;
                    end
                end
            end

            ST_LOAD_B: begin
                if (beat) begin
                    bias_valid_next = 1'b1;
                    bias_value_next = s_word;
                    layer_num_next  = 32'(layer_idx_reg) + 32'd1;
                    neuron_num_next = 32'(neuron_reg);
                    widx_next       = '0;
                    if (last_neuron && last_layer) begin
                        if (s_last) begin
                            state_next = ST_DONE;
                        end else begin
                            // Final bias must carry s_last.
                            err_next   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end else if (s_last) begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else if (last_neuron) begin
                        layer_idx_next = layer_idx_inc;
                        neuron_next    = '0;
                        state_next     = (nxt_nw == 16'd0) ? ST_LOAD_B : ST_LOAD_W;
                    end else begin
                        neuron_next = neuron_reg + 16'd1;
                        state_next  = (cur_nw == 16'd0) ? ST_LOAD_B : ST_LOAD_W;
                    end
                end
            end

            ST_DONE: begin
                // done is registered, so it lands one cycle after the last
                // bias strobe, in the same cycle busy falls.
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy              = (state_reg != ST_IDLE);
    assign config_layer_num  = layer_num_reg;
    assign config_neuron_num = neuron_num_reg;
    assign weightValue       = weight_value_reg;
    assign weightValid       = weight_valid_reg;
    assign biasValue         = bias_value_reg;
    assign biasValid         = bias_valid_reg;
    assign done              = done_reg;
    assign err               = err_reg;

endmodule

// File: doc/weight_load_sequencer.md
Name: weight_load_sequencer

Overview:
Configuration controller that streams trained weights and biases into every neuron of the layer chain. It consumes a flat AXI-Stream image of coefficients and walks the layer, neuron and weight counters. For each accepted word it drives config_layer_num, config_neuron_num and a one-cycle weightValid or biasValid strobe on the shared config bus that feeds every Layer_N instance. It sits beside axi_lite_wrapper, which keeps the single-word register write path; the two sources are muxed outside this block.

Parameters:
NUM_LAYERS, 2, number of layers to load (1..4).
LAYER_NEURONS, {16'd10,16'd30}, packed 16-bit neuron counts per layer; layer 1 in bits [15:0].
LAYER_WEIGHTS, {16'd30,16'd784}, packed 16-bit weights-per-neuron per layer; layer 1 in bits [15:0].
DATA_WIDTH, 32, coefficient word width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a load when IDLE
s_data  in  DATA_WIDTH  coefficient stream data
s_valid  in  1  stream valid
s_last  in  1  marks final word of image
s_ready  out  1  stream ready
config_layer_num  out  32  target layer, 1-based
config_neuron_num  out  32  target neuron, 0-based
weightValue  out  32  weight word, zero-extended/truncated from s_data
weightValid  out  1  one-cycle weight write strobe
biasValue  out  32  bias word
biasValid  out  1  one-cycle bias write strobe
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky framing-error flag; cleared by next accepted start or rst

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; all outputs 0; counters 0. Applies mid-load as well: the load is abandoned and no strobe is issued in the cycle after rst.
- Image order: for layer 1..NUM_LAYERS, neuron 0..NN-1: NW weight words, then 1 bias word.
- States:
  - IDLE: s_ready=0. start → LOAD_W with layer=1, neuron=0, widx=0; err cleared.
  - LOAD_W: s_ready=1. On s_valid&s_ready, emit a weight. If widx==NW-1 → LOAD_B, else widx++.
  - LOAD_B: s_ready=1. On a beat, emit a bias and set widx=0.
    - Last neuron of last layer → DONE.
    - Last neuron of a non-final layer → layer++, neuron=0, LOAD_W.
    - Otherwise neuron++, LOAD_W.
  - DONE: done=1 for exactly one cycle → IDLE.
- Output timing: all config outputs are registered; strobe, value, layer and neuron appear in the cycle after the accepting edge (latency 1).
  - weightValid and biasValid are never high together.
  - Neither strobe is high in a cycle without a preceding beat.
  - Layer and neuron outputs hold their last values between strobes.
- s_valid low stalls the walk with no strobe; counters hold.
- Framing:
  - s_last on any beat other than the final bias: that beat is still written, err=1, → IDLE with no done pulse.
  - Final bias without s_last: written, err=1, → IDLE with no done pulse.
- start while busy is ignored. start coincident with rst: rst wins.
- busy = (state != IDLE).
- Degenerate NW=0 for a layer: go straight to LOAD_B for each neuron of that layer.

Test Plan:
- Parameters NUM_LAYERS=2, LAYER_NEURONS={2,3}, LAYER_WEIGHTS={3,2}. start, then 17 back-to-back beats 1..17 with s_last on beat 17 →
  - strobe sequence W,W,B ×3 on layer 1, neurons 0,1,2; then W,W,W,B ×2 on layer 2, neurons 0,1;
  - layer-2 neuron-1 bias value 17;
  - done pulses one cycle after the last strobe; err=0.
- Same image with s_valid toggling every other cycle → identical strobe/value sequence, with no strobe in stalled cycles.
- s_last on beat 5 → beat-5 weight write issued, err=1, busy drops, no done; the next start clears err.
- Beat 17 without s_last → bias written, err=1, no done.
- rst asserted after beat 8 → next cycle: all strobes 0, busy=0, s_ready=0; a fresh start reloads from layer 1 neuron 0.
- start pulsed during LOAD_W → ignored; counters and strobe sequence unchanged.
